// File: rtl/dmemory_32.sv
// dmemory_32: word-organised data RAM for the CPU memory stage.
// The byte address comes in, and the word index is taken from address[ADDR_WIDTH+1:2].
// Writes are synchronous, and the read data is registered with write-first collision behaviour.
// An async active-low reset clears only the read register. Memory contents are kept.
module dmemory_32 #(
  parameter int ADDR_WIDTH = 14,
  // Word width is part of the datapath contract; leave at 32.
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [DATA_WIDTH-1:0] readData,
  input  logic [31:0]           address,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic                  memWrite
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // Storage starts all-zero. The declaration initialiser is honoured by sim and FPGA flows,
  // and it does not get in the way of block RAM inference.
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  wr_en;

  // Byte-offset bits and high bits are don't-care. Accesses go to the containing word,
  // and addresses alias modulo the memory size.
  assign idx = address[ADDR_WIDTH+1:2];

  logic unused_addr;
  assign unused_addr = ^{address[31:ADDR_WIDTH+2], address[1:0]};

  // Writes are blocked while reset is held low at the edge.
  assign wr_en = memWrite & reset_n;

  // Write-first: a store on the same edge returns the new data instead of the old word.
  always_comb begin
    rdata_d = mem[idx];
    if (memWrite) rdata_d = writeData;
  end

  // Memory array write port (no reset so it maps onto block RAM).
  always_ff @(posedge clock) begin
    if (wr_en) mem[idx] <= writeData;
  end

  // Registered read port; the async reset clears only the output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign readData = rdata_q;

endmodule

// File: tb/tb_dmemory_32.sv
// tb_dmemory_32: runs directed test-plan sequences and then random traffic against a word-array model.
// Each expected value goes into a queue, and a separate monitor compares it after every rising edge.
module tb_dmemory_32;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] readData;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWrite;

  dmemory_32 #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .readData  (readData),
    .address   (address),
    .writeData (writeData),
    .memWrite  (memWrite)
  );

  always #5 clock = ~clock;

  // Reference model: a sparse word store in which unwritten words read as zero.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_q [$];
  int nvec = 0;
  int nerr = 0;

  function automatic int word_of(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    int w;
    w = word_of(a);
    if (ref_mem.exists(w)) return ref_mem[w];
    return 32'h0;
  endfunction

  // Sets the inputs for one cycle (called at the falling edge) and queues the readData expected after the next rising edge.
  task automatic drive(input logic rst, input logic [31:0] a, input logic [31:0] wd, input logic we);
    @(negedge clock);
    address   = a;
    writeData = wd;
    memWrite  = we;
    reset_n   = rst;
    if (!rst) begin
      #1;
      nvec++;
      if (readData !== 32'h0) begin
        nerr++;
        $display("FAIL async_reset_clear addr=%h got=%h want=00000000", a, readData);
      end
      exp_q.push_back(32'h0);
    end else begin
      if (we) begin
        exp_q.push_back(wd);
        ref_mem[word_of(a)] = wd;
      end else begin
        exp_q.push_back(ref_read(a));
      end
    end
  endtask

  // Monitor: checks the registered value just after each edge and again late in the cycle to confirm it holds.
  initial begin
    logic [31:0] exp;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        nvec++;
        if (readData !== exp) begin
          nerr++;
          $display("FAIL read_data addr=%h got=%h want=%h", address, readData, exp);
        end
        #3;
        nvec++;
        if (readData !== exp) begin
          nerr++;
          $display("FAIL read_hold addr=%h got=%h want=%h", address, readData, exp);
        end
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    logic        we, rst;
    int          budget;
    reset_n   = 1'b1;
    address   = 32'h10;
    writeData = 32'h0;
    memWrite  = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    nvec++;
    if (readData !== 32'h0) begin
      nerr++;
      $display("FAIL reset_immediate got=%h want=00000000", readData);
    end

    // Reset, then the first read after release returns the initial zero contents.
    drive(1'b0, 32'h10, 32'h0, 1'b0);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    // Store and load, including the write-first collision case.
    drive(1'b1, 32'h10, 32'hA000_0000, 1'b0);
    drive(1'b1, 32'h10, 32'hA000_0000, 1'b0);
    drive(1'b1, 32'h10, 32'h0000_00F5, 1'b1);
    drive(1'b1, 32'h10, 32'h0000_00F5, 1'b1);
    drive(1'b1, 32'h10, 32'h0000_00F5, 1'b0);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    // Alignment and aliasing.
    drive(1'b1, 32'h20, 32'h1234_5678, 1'b1);
    drive(1'b1, 32'h23, 32'h0, 1'b0);
    drive(1'b1, 32'h0001_0020, 32'h0, 1'b0);
    // Independent words at the bottom and top of the map.
    drive(1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1);
    drive(1'b1, 32'hFFFC, 32'hCAFE_F00D, 1'b1);
    drive(1'b1, 32'h0, 32'h0, 1'b0);
    drive(1'b1, 32'hFFFC, 32'h0, 1'b0);
    drive(1'b1, 32'h4, 32'h0, 1'b0);
    // Async reset asserted mid-store: the write is dropped and the contents are kept.
    drive(1'b0, 32'h10, 32'h5555_5555, 1'b1);
    drive(1'b1, 32'h10, 32'h0, 1'b0);
    // Back-to-back stores and loads.
    drive(1'b1, 32'h40, 32'h1, 1'b1);
    drive(1'b1, 32'h44, 32'h2, 1'b1);
    drive(1'b1, 32'h40, 32'h0, 1'b0);
    drive(1'b1, 32'h44, 32'h0, 1'b0);

    // Random traffic over a small word pool so that hits and collisions are common.
    for (int i = 0; i < 400; i++) begin
      a   = {$urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 15)) : 32'h0, 16'h0}
            | (32'($urandom_range(0, 15)) * 4) | 32'($urandom_range(0, 3));
      wd  = $urandom;
      we  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 49) != 0);
      drive(rst, a, wd, we);
    end
    drive(1'b1, 32'h0, 32'h0, 1'b0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(posedge clock);
      budget++;
    end
    @(negedge clock);
    if (exp_q.size() > 0) begin
      nvec++;
      nerr++;
      $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
